sprite_line_fetch: RTL

- Consumer side of the sprite texture ROM. Once per scan line, during horizontal blanking, it fetches the T-rex and obstacle bytes for that line into line registers.
- During the active region it serialises those registers into per-pixel outputs, aligned to the horizontal position.
- It also raises a sticky collision flag when T-rex and obstacle pixels overlap.
- It sits between the VGA timing generator and the colour mux.

---
 rtl/sprite_line_fetch_if.sv | 11 +
 rtl/sprite_line_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetch_if.sv
// Texture ROM bus between sprite_line_fetch and the sprite ROM.
//   rom_addr : byte address presented by the fetcher
//   rom_data : byte returned by the ROM, combinational, valid in the same cycle
// master = fetcher side, slave = ROM side.
interface sprite_line_fetch_if;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_fetch.sv
// Sprite line fetcher and pixel serialiser.
// During hblank a line_start pulse launches a fixed 5-slot fetch of the T-rex
// and obstacle bytes for next_line into line registers. During the active
// region those registers are serialised against hpos into registered per-pixel
// outputs, and a sticky collision flag records any T-rex/obstacle overlap.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   line_start        : hblank pulse, starts (or restarts) a fetch for next_line
//   next_line         : row to display next, sampled with line_start
//   hpos, pix_en      : current column and active-pixel strobe
//   dino_x/y, obs_x/y : sprite top-left positions (x live, y at line_start)
//   obs_en            : obstacle present
//   rom               : texture ROM bus (master)
//   dino_pix, obs_pix : registered sprite pixels, pix_out is their OR
//   collide           : sticky overlap flag, collide_clr clears it
//   busy              : fetch in progress
module sprite_line_fetch #(
  parameter int DINO_BASE = 0,
  parameter int DINO_H    = 25,
  parameter int DINO_NB   = 3,
  parameter int OBS_BASE  = 75,
  parameter int OBS_H     = 28,
  parameter int OBS_NB    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       line_start,
  input  logic [9:0]                 next_line,
  input  logic [9:0]                 hpos,
  input  logic                       pix_en,
  input  logic [9:0]                 dino_x,
  input  logic [9:0]                 dino_y,
  input  logic [9:0]                 obs_x,
  input  logic [9:0]                 obs_y,
  input  logic                       obs_en,
  sprite_line_fetch_if.master        rom,
  output logic                       dino_pix,
  output logic                       obs_pix,
  output logic                       pix_out,
  output logic                       collide,
  input  logic                       collide_clr,
  output logic                       busy
);

  localparam int NSLOT = DINO_NB + OBS_NB;
  localparam int SW    = $clog2(NSLOT);
  localparam int DW    = DINO_NB * 8;
  localparam int OW    = OBS_NB * 8;
  localparam int DXW   = $clog2(DW);
  localparam int OXW   = $clog2(OW);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                    state;
  logic [SW-1:0]             slot;
  logic [10:0]               drow;   // two's complement row within T-rex
  logic [10:0]               orow;   // two's complement row within obstacle
  // Element 0 is the leftmost byte, so the flattened vector is MSB-first.
  logic [0:DINO_NB-1][7:0]   dline;
  logic [0:OBS_NB-1][7:0]    oline;

  logic                      drow_ok, orow_ok;
  logic [9:0]                addr_c;

  assign drow_ok = !drow[10] && (drow[9:0] < 10'(DINO_H));
  assign orow_ok = !orow[10] && (orow[9:0] < 10'(OBS_H));

  // The ROM answers in the same cycle, so the address is decoded from the
  // registered state/slot rather than registered itself; it is 0 whenever idle.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    addr_c = '0;
    if (state == FETCH) begin
      for (int b = 0; b < DINO_NB; b++)
        if (slot == SW'(b)) addr_c = 10'(DINO_BASE + b * DINO_H) + drow[9:0];
      for (int b = 0; b < OBS_NB; b++)
        if (slot == SW'(DINO_NB + b)) addr_c = 10'(OBS_BASE + b * OBS_H) + orow[9:0];
    end
  end

  assign rom.rom_addr = addr_c;
  assign busy         = (state == FETCH);

  // Fetch FSM and line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
      drow  <= '0;
      orow  <= '0;
      // NOTE: the line registers are reset even though they act as a small
      // memory: stale bytes would otherwise be drawn as pixels after reset.
      dline <= '0;
      oline <= '0;
    end else if (line_start) begin
      // A new line_start always wins: an in-flight fetch is abandoned.
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= FETCH;
      slot  <= '0;
      drow  <= {1'b0, next_line} - {1'b0, dino_y};
      orow  <= {1'b0, next_line} - {1'b0, obs_y};
    end else if (state == FETCH) begin
      for (int b = 0; b < DINO_NB; b++)
        if (slot == SW'(b)) dline[b] <= drow_ok ? rom.rom_data : 8'h00;
      for (int b = 0; b < OBS_NB; b++)
        if (slot == SW'(DINO_NB + b)) oline[b] <= (obs_en && orow_ok) ? rom.rom_data : 8'h00;
      if (slot == SW'(NSLOT - 1)) begin
        state <= IDLE;
        slot  <= '0;
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  // Pixel path: offsets into each sprite, 11-bit so left-of-sprite is negative.
  logic [10:0]   dx, ox;
  logic          dx_ok, ox_ok;
  logic [DW-1:0] dshift;
  logic [OW-1:0] oshift;

  assign dx     = {1'b0, hpos} - {1'b0, dino_x};
  assign ox     = {1'b0, hpos} - {1'b0, obs_x};
  assign dx_ok  = !dx[10] && (dx[9:0] < 10'(DW));
  assign ox_ok  = !ox[10] && (ox[9:0] < 10'(OW));
  // Shifting left by the offset brings bit (W-1-offset) to the MSB.
  assign dshift = dline << dx[DXW-1:0];
  assign oshift = oline << ox[OXW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      dino_pix <= 1'b0;
      obs_pix  <= 1'b0;
      collide  <= 1'b0;
    end else begin
      dino_pix <= pix_en && dx_ok && dshift[DW-1];
      obs_pix  <= pix_en && obs_en && ox_ok && oshift[OW-1];
      // Set has priority over clear so a coincident overlap is never lost.
      if (dino_pix && obs_pix) collide <= 1'b1;
      else if (collide_clr)    collide <= 1'b0;
    end
  end

  assign pix_out = dino_pix | obs_pix;

endmodule
